// File: rtl/adc_cmd_pkg.sv
// Shared definitions for the ADC command SPI master.
// Holds the command prefix constants, the mask bit positions, the
// frame FSM state type and a prefix check helper.
package adc_cmd_pkg;

  localparam logic [1:0] SETUP_PFX = 2'b01;
  localparam logic [2:0] AVER_PFX  = 3'b001;
  localparam logic       CONV_PFX  = 1'b1;

  localparam int MSK_SETUP = 0;
  localparam int MSK_AVER  = 1;
  localparam int MSK_CONV  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    GAP,
    TAIL
  } state_t;

  // Returns one bit per command (mask bit order), set when the prefix matches.
  function automatic logic [2:0] prefix_ok(input logic [1:0] setup_pfx,
                                           input logic [2:0] aver_pfx,
                                           input logic       conv_pfx);
    prefix_ok = {conv_pfx == CONV_PFX, aver_pfx == AVER_PFX, setup_pfx == SETUP_PFX};
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Phase counter shared by all timed phases of the frame FSM.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - restart the phase with load_val cycles
//   load_val    - phase length in cycles (>=1)
//   phase_end   - high during the last cycle of the loaded phase
module spi_bit_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase loaded with N lasts N cycles; the final one sees cnt==1.
  assign phase_end = (cnt == CNT_W'(1));

endmodule

// File: rtl/adc_cmd_spi_master.sv
// Serial command driver for the ADC configuration interface.
// Shifts up to three command bytes (setup, aver, conv) MSB-first on
// sclk/en/mosi. Bytes with a bad prefix are dropped and flagged.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   start          - one-cycle frame request, ignored while busy
//   mask           - byte enables [0]=setup [1]=aver [2]=conv
//   setup_byte, aver_byte, conv_byte - command bytes
//   sclk, en, mosi - serial interface to the ADC
//   busy           - frame in progress
//   done           - one-cycle end-of-frame pulse
//   cmd_err        - per-byte prefix error, held until next accepted start
module adc_cmd_spi_master
  import adc_cmd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mask,
  input  logic [7:0] setup_byte,
  input  logic [7:0] aver_byte,
  input  logic [7:0] conv_byte,
  output logic       sclk,
  output logic       en,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [2:0] cmd_err
);

  localparam int PH_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] DIV_LD = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] GAP_LD = PH_W'(GAP_CYCLES);

  state_t          state, state_d;
  logic [3:0][7:0] send_q, send_d;
  logic [1:0]      n_bytes, n_d, byte_idx;
  logic [2:0]      bit_idx;
  logic            empty_p;
  logic [2:0]      ok, err_d;

  logic            tmr_load;
  logic [PH_W-1:0] tmr_val;
  logic            phase_end;

  logic            accept, step_bit, step_byte, gap_end, frame_end;

  spi_bit_timer #(.CNT_W(PH_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .phase_end (phase_end)
  );

  // Send list: valid enabled bytes packed in fixed order setup, aver, conv.
  always_comb begin
    ok     = prefix_ok(setup_byte[7:6], aver_byte[7:5], conv_byte[7]) & mask;
    err_d  = mask & ~ok;
    send_d = '0;
    n_d    = '0;
    if (ok[MSK_SETUP]) begin
      send_d[n_d] = setup_byte;
      n_d         = n_d + 2'd1;
    end
    if (ok[MSK_AVER]) begin
      send_d[n_d] = aver_byte;
      n_d         = n_d + 2'd1;
    end
    if (ok[MSK_CONV]) begin
      send_d[n_d] = conv_byte;
      n_d         = n_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    tmr_load  = 1'b0;
    tmr_val   = DIV_LD;
    accept    = 1'b0;
    step_bit  = 1'b0;
    step_byte = 1'b0;
    gap_end   = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        // empty_p marks the busy cycle of an empty frame; start is ignored there.
        if (start && !empty_p) begin
          accept = 1'b1;
          if (n_d != 2'd0) begin
            state_d  = LOW;
            tmr_load = 1'b1;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          if (bit_idx != 3'd0) begin
            state_d  = LOW;
            tmr_load = 1'b1;
            step_bit = 1'b1;
          end else if (byte_idx != n_bytes - 2'd1) begin
            step_byte = 1'b1;
            tmr_load  = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              tmr_val = GAP_LD;
            end else begin
              state_d = LOW;
            end
          end else begin
            // Tail keeps sclk low long enough for the ADC commit edge.
            state_d  = TAIL;
            tmr_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          gap_end  = 1'b1;
        end
      end
      TAIL: begin
        if (phase_end) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      send_q <= send_d;
    end
  end

  // mosi only moves on entry to LOW/GAP, i.e. with sclk already low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi     <= 1'b0;
      bit_idx  <= '0;
      byte_idx <= '0;
      n_bytes  <= '0;
      cmd_err  <= '0;
      done     <= 1'b0;
      empty_p  <= 1'b0;
    end else begin
      done    <= frame_end | empty_p;
      empty_p <= accept && (n_d == 2'd0);
      if (accept) begin
        cmd_err  <= err_d;
        n_bytes  <= n_d;
        byte_idx <= 2'd0;
        bit_idx  <= 3'd7;
        mosi     <= send_d[0][7];
      end
      if (step_bit) begin
        bit_idx <= bit_idx - 3'd1;
        mosi    <= send_q[byte_idx][bit_idx - 3'd1];
      end
      if (step_byte) begin
        byte_idx <= byte_idx + 2'd1;
        bit_idx  <= 3'd7;
        mosi     <= (GAP_CYCLES > 0) ? 1'b0 : send_q[byte_idx + 2'd1][7];
      end
      if (gap_end) begin
        mosi <= send_q[byte_idx][7];
      end
      if (frame_end) begin
        mosi <= 1'b0;
      end
    end
  end

  assign sclk = (state == HIGH);
  assign en   = (state != IDLE);
  assign busy = (state != IDLE) || empty_p;

endmodule

// File: tb/tb_adc_cmd_spi_master.sv
// Bench for adc_cmd_spi_master: two instances (CLK_DIV=2/GAP=2 and
// CLK_DIV=1/GAP=0), a table of hand-derived frames, randomized frames
// checked against a frame-level model, and hand-written corner sequences
// (start while busy, start in the done cycle, reset mid-frame).
module tb_adc_cmd_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] mask = '0;
  logic [7:0] setup_byte = '0, aver_byte = '0, conv_byte = '0;

  logic       sclk_a, en_a, mosi_a, busy_a, done_a;
  logic [2:0] cmd_err_a;
  logic       sclk_b, en_b, mosi_b, busy_b, done_b;
  logic [2:0] cmd_err_b;

  always #5 clk = ~clk;

  adc_cmd_spi_master #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mask(mask),
    .setup_byte(setup_byte), .aver_byte(aver_byte), .conv_byte(conv_byte),
    .sclk(sclk_a), .en(en_a), .mosi(mosi_a), .busy(busy_a), .done(done_a),
    .cmd_err(cmd_err_a)
  );

  adc_cmd_spi_master #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mask(mask),
    .setup_byte(setup_byte), .aver_byte(aver_byte), .conv_byte(conv_byte),
    .sclk(sclk_b), .en(en_b), .mosi(mosi_b), .busy(busy_b), .done(done_b),
    .cmd_err(cmd_err_b)
  );

  logic       sel = 1'b0;
  logic       sclk_m, en_m, mosi_m, busy_m, done_m;
  logic [2:0] err_m;
  assign sclk_m = sel ? sclk_b : sclk_a;
  assign en_m   = sel ? en_b   : en_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign err_m  = sel ? cmd_err_b : cmd_err_a;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Measurements of one frame, filled by run_frame.
  int         m_done, m_en, m_en_first, m_rise, m_high, m_viol, m_busy_bad, m_done_after;
  logic [2:0] m_err;
  logic [7:0] m_bytes[$];

  // Frame-level model: which bytes survive the prefix check and how long the frame is.
  function automatic void model(input logic [2:0] mk, input logic [7:0] s, a, c,
                                input int cd, input int g,
                                output logic [2:0] err, output int done_cyc,
                                output int n, output logic [23:0] bytes);
    logic [7:0] cand[3];
    logic       good[3];
    cand[0] = s; cand[1] = a; cand[2] = c;
    good[0] = (s[7:6] == 2'b01);
    good[1] = (a[7:5] == 3'b001);
    good[2] = c[7];
    err = '0; n = 0; bytes = '0;
    for (int i = 0; i < 3; i++) begin
      if (mk[i]) begin
        if (good[i]) begin
          bytes[23 - 8*n -: 8] = cand[i];
          n++;
        end else begin
          err[i] = 1'b1;
        end
      end
    end
    done_cyc = (n == 0) ? 2 : 1 + n*16*cd + (n-1)*g + cd;
  endfunction

  // Starts a frame at the current negedge (cycle 0) and watches it to done.
  // The serial stream is decoded the way the ADC receiver does it.
  task automatic run_frame(input bit use_b, input logic [2:0] mk,
                           input logic [7:0] s, a, c,
                           input int restart_at, input bit chain);
    logic       prev_sclk, prev_mosi;
    logic [7:0] sh;
    int         nb;
    sel = use_b;
    mask = mk; setup_byte = s; aver_byte = a; conv_byte = c;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    m_done = -1; m_en = 0; m_en_first = -1; m_rise = 0; m_high = 0;
    m_viol = 0; m_busy_bad = 0; m_done_after = 0; m_err = '0;
    m_bytes.delete();
    prev_sclk = 1'b0; prev_mosi = 1'b0; sh = '0; nb = 0;
    @(negedge clk);
    for (int k = 1; k <= 400; k++) begin
      start_a = 1'b0; start_b = 1'b0;
      if (en_m) begin
        m_en++;
        if (m_en_first < 0) m_en_first = k;
      end
      if (sclk_m) m_high++;
      if (sclk_m && prev_sclk && (mosi_m !== prev_mosi)) m_viol++;
      if (sclk_m && !prev_sclk && en_m) begin
        m_rise++;
        sh = {sh[6:0], mosi_m};
        nb++;
      end
      if (!sclk_m && prev_sclk && nb == 8) begin
        m_bytes.push_back(sh);
        nb = 0;
      end
      if (done_m) begin
        m_done = k;
        m_err  = err_m;
        if (busy_m) m_busy_bad++;
        break;
      end else if (!busy_m) begin
        m_busy_bad++;
      end
      prev_sclk = sclk_m;
      prev_mosi = mosi_m;
      if (k == restart_at) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        mask = 3'b001; setup_byte = 8'h7C; aver_byte = 8'hFF; conv_byte = 8'h00;
      end
      @(negedge clk);
    end
    if (chain) begin
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
    end else begin
      @(negedge clk);
      m_done_after = done_m;
    end
  endtask

  task automatic check_frame(input string tag, input bit use_b, input logic [2:0] exp_err,
                             input int exp_done, input int n, input logic [23:0] exp_bytes,
                             input bit chained);
    int cd;
    cd = use_b ? 1 : 2;
    chk({tag, " done_cycle"}, m_done, exp_done);
    chk({tag, " cmd_err"}, m_err, exp_err);
    chk({tag, " en_cycles"}, m_en, (n == 0) ? 0 : exp_done - 1);
    chk({tag, " sclk_rises"}, m_rise, 8*n);
    chk({tag, " sclk_high"}, m_high, 8*n*cd);
    chk({tag, " mosi_while_high"}, m_viol, 0);
    chk({tag, " busy_shape"}, m_busy_bad, 0);
    chk({tag, " adc_bytes"}, m_bytes.size(), n);
    for (int i = 0; i < n && i < m_bytes.size(); i++)
      chk({tag, $sformatf(" adc_byte%0d", i)}, m_bytes[i], exp_bytes[23 - 8*i -: 8]);
    if (n > 0) chk({tag, " en_first"}, m_en_first, 1);
    if (!chained) chk({tag, " done_single"}, m_done_after, 0);
  endtask

  typedef struct {
    bit         use_b;
    logic [2:0] mk;
    logic [7:0] s, a, c;
    logic [2:0] err;
    int         done_cyc;
    int         n;
    logic [23:0] bytes;
  } vec_t;

  initial begin
    vec_t       tbl[7];
    logic [2:0] e_err;
    int         e_done, e_n, cnt;
    logic [23:0] e_bytes;
    bit         ub;
    logic [2:0] mk;
    logic [7:0] s, a, c;

    tbl[0] = '{0, 3'b111, 8'h55, 8'h2A, 8'h83, 3'b000, 103, 3, 24'h552A83};
    tbl[1] = '{0, 3'b100, 8'h00, 8'h00, 8'h41, 3'b100,   2, 0, 24'h000000};
    tbl[2] = '{0, 3'b011, 8'h7C, 8'hFF, 8'h00, 3'b010,  35, 1, 24'h7C0000};
    tbl[3] = '{0, 3'b000, 8'h55, 8'h2A, 8'h83, 3'b000,   2, 0, 24'h000000};
    tbl[4] = '{0, 3'b101, 8'h40, 8'h00, 8'hFF, 3'b000,  69, 2, 24'h40FF00};
    tbl[5] = '{1, 3'b111, 8'h55, 8'h2A, 8'h83, 3'b000,  50, 3, 24'h552A83};
    tbl[6] = '{1, 3'b110, 8'h00, 8'h3F, 8'h7F, 3'b100,  18, 1, 24'h3F0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset sclk_a", sclk_a, 0);
    chk("reset en_a", en_a, 0);
    chk("reset mosi_a", mosi_a, 0);
    chk("reset busy_a", busy_a, 0);
    chk("reset done_a", done_a, 0);
    chk("reset cmd_err_a", cmd_err_a, 0);
    chk("reset en_b", en_b, 0);
    chk("reset busy_b", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    foreach (tbl[i]) begin
      run_frame(tbl[i].use_b, tbl[i].mk, tbl[i].s, tbl[i].a, tbl[i].c, 0, 0);
      check_frame($sformatf("vec%0d", i), tbl[i].use_b, tbl[i].err, tbl[i].done_cyc,
                  tbl[i].n, tbl[i].bytes, 0);
    end

    // Randomized frames against the model
    for (int r = 0; r < 12; r++) begin
      ub = $urandom_range(0, 1);
      mk = 3'($urandom_range(0, 7));
      s  = 8'($urandom); a = 8'($urandom); c = 8'($urandom);
      if ($urandom_range(0, 3) != 0) s[7:6] = 2'b01;
      if ($urandom_range(0, 3) != 0) a[7:5] = 3'b001;
      if ($urandom_range(0, 3) != 0) c[7] = 1'b1;
      model(mk, s, a, c, ub ? 1 : 2, ub ? 0 : 2, e_err, e_done, e_n, e_bytes);
      run_frame(ub, mk, s, a, c, 0, 0);
      check_frame($sformatf("rnd%0d", r), ub, e_err, e_done, e_n, e_bytes, 0);
    end

    // start while busy at cycle 40 is ignored; new inputs must not leak in
    run_frame(0, 3'b111, 8'h55, 8'h2A, 8'h83, 40, 0);
    check_frame("restart_busy", 0, 3'b000, 103, 3, 24'h552A83, 0);

    // start in the done cycle is accepted; en rises the following cycle
    run_frame(0, 3'b011, 8'h7C, 8'hFF, 8'h00, 0, 1);
    check_frame("chain_first", 0, 3'b010, 35, 1, 24'h7C0000, 1);
    run_frame(0, 3'b001, 8'h40, 8'h00, 8'h00, 0, 0);
    check_frame("chain_second", 0, 3'b000, 35, 1, 24'h400000, 0);

    // Reset in the middle of a byte (cycle 20 is a HIGH phase of bit 3)
    sel = 1'b0;
    mask = 3'b001; setup_byte = 8'h7F; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (19) @(negedge clk);
    chk("midreset pre busy", busy_a, 1);
    chk("midreset pre sclk", sclk_a, 1);
    chk("midreset pre mosi", mosi_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset sclk", sclk_a, 0);
    chk("midreset en", en_a, 0);
    chk("midreset mosi", mosi_a, 0);
    chk("midreset busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a || busy_a || en_a) cnt++;
    end
    chk("postreset quiet", cnt, 0);
    run_frame(0, 3'b111, 8'h55, 8'h2A, 8'h83, 0, 0);
    check_frame("postreset_frame", 0, 3'b000, 103, 3, 24'h552A83, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
